// File: rtl/gpio_pkg.sv
// Shared constants for the Avalon-MM GPIO peripheral: register map and bus widths.
package gpio_pkg;

    localparam int GPIO_MAX_WIDTH = 32;
    localparam int GPIO_BUS_W     = 32;
    localparam int GPIO_ADDR_W    = 3;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_DATA    = 3'd0;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_DIR     = 3'd1;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_SET     = 3'd2;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_CLR     = 3'd3;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_MASK    = 3'd4;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_CAPTURE = 3'd5;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_RISE_EN = 3'd6;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_FALL_EN = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs; output is the last stage.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH  = GPIO_MAX_WIDTH,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) chain_q <= '0;
        else       chain_q <= {chain_q[STAGES-2:0], d_i};
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/avalon_gpio_irq.sv
// Avalon-MM GPIO: direction/output registers, atomic set/clear, synchronised
// inputs with per-pin rise/fall edge capture and a masked, registered interrupt.
module avalon_gpio_irq
    import gpio_pkg::*;
#(
    parameter int                    WIDTH       = GPIO_MAX_WIDTH,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [GPIO_BUS_W-1:0] RESET_OUT   = '0,
    parameter logic [GPIO_BUS_W-1:0] RESET_DIR   = '0
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [GPIO_ADDR_W-1:0] avs_address,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [GPIO_BUS_W-1:0]  avs_writedata,
    output logic [GPIO_BUS_W-1:0]  avs_readdata,
    output logic                   avs_readdatavalid,
    input  logic [WIDTH-1:0]       gpio_in,
    output logic [WIDTH-1:0]       gpio_out,
    output logic [WIDTH-1:0]       gpio_oe,
    output logic                   irq
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] prev_q;
    logic             irq_q;
    logic [GPIO_BUS_W-1:0] rdata_q, rdata_d;
    logic             rvalid_q;

    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] rsel;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_clk),
        .rst_i (reset_reset),
        .d_i   (gpio_in),
        .q_o   (samp)
    );

    assign wdata = avs_writedata[WIDTH-1:0];
    assign edges = (samp & ~prev_q & rise_q) | (~samp & prev_q & fall_q);

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        cap_d  = cap_q | edges;
        rise_d = rise_q;
        fall_d = fall_q;
        if (avs_write) begin
            case (avs_address)
                GPIO_DATA:    out_d  = wdata;
                GPIO_DIR:     dir_d  = wdata;
                GPIO_SET:     out_d  = out_q | wdata;
                GPIO_CLR:     out_d  = out_q & ~wdata;
                GPIO_MASK:    mask_d = wdata;
                // New edges are OR-ed after the clear so a coincident edge survives.
                GPIO_CAPTURE: cap_d  = (cap_q & ~wdata) | edges;
                GPIO_RISE_EN: rise_d = wdata;
                GPIO_FALL_EN: fall_d = wdata;
                default:      ;
            endcase
        end
    end

    always_comb begin
        rsel = '0;
        case (avs_address)
            GPIO_DATA:    rsel = samp;
            GPIO_DIR:     rsel = dir_q;
            GPIO_MASK:    rsel = mask_q;
            GPIO_CAPTURE: rsel = cap_q;
            GPIO_RISE_EN: rsel = rise_q;
            GPIO_FALL_EN: rsel = fall_q;
            default:      rsel = '0;
        endcase
        rdata_d = '0;
        if (avs_read) rdata_d[WIDTH-1:0] = rsel;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            out_q    <= RESET_OUT[WIDTH-1:0];
            dir_q    <= RESET_DIR[WIDTH-1:0];
            mask_q   <= '0;
            cap_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            prev_q   <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            prev_q   <= samp;
            irq_q    <= |(cap_q & mask_q);
            rdata_q  <= rdata_d;
            rvalid_q <= avs_read;
        end
    end

    assign gpio_out          = out_q;
    assign gpio_oe           = dir_q;
    assign irq               = irq_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_avalon_gpio_irq.sv
// Self-checking bench: directed register/edge/irq scenarios then random bus and
// pad traffic, all compared every cycle against a history-based reference model.
module tb_avalon_gpio_irq;

    localparam int W = 16;
    localparam int S = 3;
    localparam logic [31:0] RO = 32'h0000_00A5;
    localparam logic [31:0] RD = 32'h0000_000F;

    logic          clk_clk = 1'b0;
    logic          reset_reset = 1'b1;
    logic [2:0]    avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic [W-1:0]  gpio_in = '0;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oe;
    logic          irq;

    avalon_gpio_irq #(
        .WIDTH(W), .SYNC_STAGES(S), .RESET_OUT(RO), .RESET_DIR(RD)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk_clk = ~clk_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pad history per clock edge; the synchronised sample after
    // edge k is the pad value sampled S-1 edges earlier, if that edge followed reset.
    int k = 0;
    int r = 0;
    logic [W-1:0] log_in [0:8191];
    logic [W-1:0] m_out, m_dir, m_mask, m_cap, m_rise, m_fall;
    logic         m_irq, m_rv;
    logic [31:0]  m_rd;

    function automatic logic [W-1:0] s_after(input int kk);
        if (kk - (S - 1) > r) return log_in[kk - S + 1];
        return '0;
    endfunction

    function automatic logic [W-1:0] p_after(input int kk);
        if (kk > r) return s_after(kk - 1);
        return '0;
    endfunction

    initial begin : model
        logic [W-1:0] sp, pp, ed, wd, ncap, nout, ndir, nmask, nrise, nfall, rv;
        forever begin
            @(posedge clk_clk);
            k++;
            log_in[k] = gpio_in;
            if (reset_reset) begin
                r = k;
                m_out = RO[W-1:0]; m_dir = RD[W-1:0];
                m_mask = '0; m_cap = '0; m_rise = '0; m_fall = '0;
                m_irq = 1'b0; m_rv = 1'b0; m_rd = '0;
            end else begin
                sp = s_after(k - 1);
                pp = p_after(k - 1);
                ed = (sp & ~pp & m_rise) | (~sp & pp & m_fall);
                wd = avs_writedata[W-1:0];
                rv = '0;
                case (avs_address)
                    3'd0: rv = sp;
                    3'd1: rv = m_dir;
                    3'd4: rv = m_mask;
                    3'd5: rv = m_cap;
                    3'd6: rv = m_rise;
                    3'd7: rv = m_fall;
                    default: rv = '0;
                endcase
                ncap = m_cap | ed; nout = m_out; ndir = m_dir;
                nmask = m_mask; nrise = m_rise; nfall = m_fall;
                if (avs_write) begin
                    case (avs_address)
                        3'd0: nout = wd;
                        3'd1: ndir = wd;
                        3'd2: nout = m_out | wd;
                        3'd3: nout = m_out & ~wd;
                        3'd4: nmask = wd;
                        3'd5: ncap = (m_cap & ~wd) | ed;
                        3'd6: nrise = wd;
                        3'd7: nfall = wd;
                        default: ;
                    endcase
                end
                m_irq = (m_cap & m_mask) != '0;
                m_rv  = avs_read;
                m_rd  = avs_read ? {{(32-W){1'b0}}, rv} : 32'h0;
                m_out = nout; m_dir = ndir; m_mask = nmask;
                m_cap = ncap; m_rise = nrise; m_fall = nfall;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk_clk);
            if (k > 0) begin
                chk("gpio_out", 32'(gpio_out), 32'(m_out));
                chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
                chk("irq", 32'(irq), 32'(m_irq));
                chk("rdvalid", 32'(avs_readdatavalid), 32'(m_rv));
                chk("rdata", avs_readdata, m_rd);
            end
        end
    end

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk_clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk_clk);
        d = avs_readdata;
        avs_read = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] d;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        chk("rst_out", 32'(gpio_out), 32'h0000_00A5);
        chk("rst_oe", 32'(gpio_oe), 32'h0000_000F);
        chk("rst_irq", 32'(irq), 32'h0);
        for (int a = 4; a < 8; a++) begin
            bus_rd(3'(a), d);
            chk("rst_reg", d, 32'h0);
        end

        bus_wr(3'd0, 32'h0000_00FF);
        bus_wr(3'd2, 32'h0000_F000);
        bus_wr(3'd3, 32'h0000_000F);
        chk("set_clr_out", 32'(gpio_out), 32'h0000_F0F0);
        bus_wr(3'd1, 32'hFFFF_FFFF);
        bus_rd(3'd1, d);
        chk("dir_width", d, 32'h0000_FFFF);

        bus_wr(3'd6, 32'h1);
        bus_wr(3'd4, 32'h1);
        gpio_in[0] = 1'b1;
        repeat (6) @(negedge clk_clk);
        bus_rd(3'd5, d);
        chk("rise_cap", d, 32'h1);
        chk("rise_irq", 32'(irq), 32'h1);
        bus_wr(3'd5, 32'h1);
        chk("w1c_irq_hold", 32'(irq), 32'h1);
        @(negedge clk_clk);
        chk("w1c_irq_drop", 32'(irq), 32'h0);

        bus_wr(3'd7, 32'h2);
        bus_wr(3'd4, 32'h0);
        gpio_in[1] = 1'b1;
        repeat (6) @(negedge clk_clk);
        gpio_in[1] = 1'b0;
        repeat (6) @(negedge clk_clk);
        bus_rd(3'd5, d);
        chk("fall_cap", d, 32'h2);
        chk("fall_irq_masked", 32'(irq), 32'h0);
        bus_wr(3'd4, 32'h2);
        chk("mask_irq_lag", 32'(irq), 32'h0);
        @(negedge clk_clk);
        chk("mask_irq_up", 32'(irq), 32'h1);
        bus_wr(3'd5, 32'h2);

        // Rising edge on bit0 reaches the compare on the same edge as the W1C.
        gpio_in[0] = 1'b0;
        repeat (6) @(negedge clk_clk);
        gpio_in[0] = 1'b1;
        repeat (3) @(negedge clk_clk);
        bus_wr(3'd5, 32'h1);
        bus_rd(3'd5, d);
        chk("set_wins", d, 32'h1);

        avs_address = 3'd1; avs_writedata = 32'h0000_1234;
        avs_read = 1'b1; avs_write = 1'b1;
        @(negedge clk_clk);
        avs_read = 1'b0; avs_write = 1'b0;
        chk("rw_dir_old", avs_readdata, 32'h0000_FFFF);
        chk("rw_dir_valid", 32'(avs_readdatavalid), 32'h1);
        chk("rw_dir_new", 32'(gpio_oe), 32'h0000_1234);
        avs_address = 3'd0; avs_writedata = 32'h0000_5555;
        avs_read = 1'b1; avs_write = 1'b1;
        @(negedge clk_clk);
        avs_read = 1'b0; avs_write = 1'b0;
        chk("rw_data_in", avs_readdata, 32'h0000_0001);
        chk("rw_data_out", 32'(gpio_out), 32'h0000_5555);

        avs_address = 3'd1; avs_read = 1'b1; reset_reset = 1'b1;
        @(negedge clk_clk);
        avs_read = 1'b0; reset_reset = 1'b0;
        chk("rst_drop_valid", 32'(avs_readdatavalid), 32'h0);
        chk("rst_mid_out", 32'(gpio_out), 32'h0000_00A5);

        for (int i = 0; i < 2500; i++) begin
            reset_reset   = ($urandom_range(0, 299) == 0);
            avs_read      = 1'($urandom_range(0, 1));
            avs_write     = ($urandom_range(0, 2) == 0);
            avs_address   = 3'($urandom_range(0, 7));
            avs_writedata = $urandom;
            if ($urandom_range(0, 3) == 0) gpio_in = W'($urandom);
            @(negedge clk_clk);
        end
        reset_reset = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
        repeat (2) @(negedge clk_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
